// File: rtl/hart_scheduler.sv
`default_nettype none
// ============================================================================
// hart_scheduler : round-robin barrel-thread issue scheduler, one PC per hart
// Revision 1.0
// ============================================================================
module hart_scheduler #(
  parameter int unsigned              NUM_HARTS     = 4,
  parameter int unsigned              HART_ID_WIDTH = 2,
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned              PC_STRIDE     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_HARTS-1:0]     hart_en_i,
  input  logic [NUM_HARTS-1:0]     block_set_i,
  input  logic [NUM_HARTS-1:0]     block_clr_i,
  input  logic                     redirect_valid_i,
  input  logic [HART_ID_WIDTH-1:0] redirect_hart_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  input  logic                     issue_ready_i,
  output logic                     issue_valid_o,
  output logic [HART_ID_WIDTH-1:0] issue_hart_o,
  output logic [ADDRESS_WIDTH-1:0] issue_pc_o,
  output logic [NUM_HARTS-1:0]     hart_blocked_o
);

  localparam logic [ADDRESS_WIDTH-1:0] c_pc_stride = ADDRESS_WIDTH'(PC_STRIDE);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_HARTS];
  logic [NUM_HARTS-1:0]     blocked_q;
  logic [NUM_HARTS-1:0]     blocked_d;
  logic [HART_ID_WIDTH-1:0] rr_ptr_q;
  logic                     issue_valid_q;
  logic [HART_ID_WIDTH-1:0] issue_hart_q;
  logic [ADDRESS_WIDTH-1:0] issue_pc_q;

  logic [NUM_HARTS-1:0]     w_elig;
  logic [HART_ID_WIDTH-1:0] w_sel;
  logic                     w_found;
  logic                     w_adv;

  // A hart being redirected this cycle sits out so its stale PC is never issued.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      w_elig[i] = hart_en_i[i] & ~blocked_q[i] &
                  ~(redirect_valid_i && (redirect_hart_i == HART_ID_WIDTH'(i)));
    end
  end

  always_comb begin
    logic [HART_ID_WIDTH-1:0] idx;
    idx     = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_HARTS; k++) begin
      idx = rr_ptr_q + HART_ID_WIDTH'(k);
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
    end
  end

  assign w_adv     = ~issue_valid_q | issue_ready_i;
  assign blocked_d = ((blocked_q | block_set_i) & ~block_clr_i) | (block_set_i & block_clr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_HARTS; i++) pc_q[i] <= RESET_PC;
      blocked_q     <= '0;
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_hart_q  <= '0;
      issue_pc_q    <= '0;
    end else begin
      blocked_q <= blocked_d;
      if (w_adv) begin
        issue_valid_q <= w_found;
        if (w_found) begin
          issue_hart_q <= w_sel;
          issue_pc_q   <= pc_q[w_sel];
          pc_q[w_sel]  <= pc_q[w_sel] + c_pc_stride;
          rr_ptr_q     <= w_sel + HART_ID_WIDTH'(1);
        end
      end
      // Redirect is written last so it beats the increment.
      if (redirect_valid_i) pc_q[redirect_hart_i] <= redirect_pc_i;
    end
  end

  assign issue_valid_o  = issue_valid_q;
  assign issue_hart_o   = issue_hart_q;
  assign issue_pc_o     = issue_pc_q;
  assign hart_blocked_o = blocked_q;

endmodule
`default_nettype wire

// File: doc/hart_scheduler.md
Name: hart_scheduler

Overview:
Barrel-thread issue scheduler for the multithreaded RV32 core. It holds one PC per hart and picks one eligible hart per cycle in rotating round-robin order. It presents the selected hart ID and PC to fetch through a valid/ready handshake. It also tracks per-hart blocked state, which the memory/LSU side uses for long-latency waits, and applies control-flow redirects from execute.

Parameters:
NUM_HARTS, 4, number of hardware threads (power of two, at least 2)
HART_ID_WIDTH, 2, log2(NUM_HARTS)
ADDRESS_WIDTH, 32, PC width
RESET_PC, 32'h0000_0000, PC loaded into every hart on reset
PC_STRIDE, 4, PC increment per issued instruction

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
hart_en  input  NUM_HARTS  per-hart enable mask; 0 = hart never selected
block_set  input  NUM_HARTS  pulse; mark hart blocked
block_clr  input  NUM_HARTS  pulse; mark hart unblocked
redirect_valid  input  1  execute redirect strobe
redirect_hart  input  HART_ID_WIDTH  hart being redirected
redirect_pc  input  ADDRESS_WIDTH  new PC for that hart
issue_ready  input  1  fetch accepts issue this cycle
issue_valid  output  1  issue_hart/issue_pc valid
issue_hart  output  HART_ID_WIDTH  selected hart
issue_pc  output  ADDRESS_WIDTH  PC of selected hart
hart_blocked  output  NUM_HARTS  registered blocked state per hart

Behaviour:
- Reset is synchronous and active-high; clk is the only clock.
- On rst: every pc[i]=RESET_PC, blocked=0, rr_ptr=0, issue_valid=0, issue_hart=0, issue_pc=0. rst overrides every other input in the same cycle.
- Eligibility, combinational: elig[i] = hart_en[i] & ~blocked[i] & ~(redirect_valid & redirect_hart==i).
- A redirected hart is excluded from selection in its redirect cycle. It becomes eligible the next cycle with the new PC.
- Advance condition: adv = ~issue_valid | issue_ready.
- Selection: the first eligible hart scanning rr_ptr, rr_ptr+1, ... with modulo NUM_HARTS wrap.
- On adv with at least one eligible hart h, all registered next cycle:
  - issue_valid=1, issue_hart=h, issue_pc=pc[h];
  - pc[h] += PC_STRIDE, wrapping modulo 2^ADDRESS_WIDTH;
  - rr_ptr = h+1 mod NUM_HARTS.
- On adv with no eligible hart: issue_valid=0 next cycle; rr_ptr and all PCs unchanged.
- On ~adv (valid & ~ready): issue_valid, issue_hart and issue_pc hold stable. No PC increments and no pointer change.
- Latency: one cycle from an eligibility change to its effect on issue outputs.
- Redirect: pc[redirect_hart] <= redirect_pc.
  - Redirect has priority over the increment. Exclusion guarantees they never target the same hart in one cycle.
  - A held, not-yet-accepted issue for the redirected hart is not retracted; the pipeline flushes it downstream.
- Blocked state:
  - blocked[i] <= (blocked[i] | block_set[i]) & ~block_clr[i] | (block_set[i] & block_clr[i]), i.e. set wins when both are asserted.
  - hart_blocked = blocked register.
  - A block asserted in cycle t prevents selection from cycle t+1.
- Fairness: with k eligible harts and ready held high, each hart issues exactly once per k accepted issues. No hart issues twice consecutively while another hart is eligible.
- Dropping hart_en[i] keeps pc[i] unchanged. Re-enabling the hart resumes from the saved PC.

Test Plan:
- rst 1 cycle, hart_en=4'hF, issue_ready=1 -> accepted issues (hart,pc) = (0,0),(1,0),(2,0),(3,0),(0,4),(1,4); issue_valid rises the cycle after rst drops.
- Backpressure: drop issue_ready for 3 cycles while showing (2,0) -> outputs hold (2,0); on ready, the next issue is (3,0); hart 2 pc advanced only once.
- block_set[1] pulse, then block_clr[1] after 6 cycles -> sequence skips hart 1 (0,2,3,0,2,...); hart_blocked[1]=1 during; hart 1 resumes after clr; set and clr in the same cycle leaves blocked=1.
- redirect_valid, hart 2, pc 0x100 while hart 2 would be next -> hart 3 is chosen that cycle; the next hart-2 issues carry 0x100 then 0x104.
- hart_en=4'b0100 only -> hart 2 issues every cycle with pc 0,4,8,...; hart_en=0 -> issue_valid=0 and PCs frozen.
- rst asserted mid-stream with issue_valid=1 and ready=0 -> next cycle issue_valid=0, all PCs 0, blocked=0, sequence restarts at hart 0.
